// File: rtl/alu_muldiv.sv
// Iterative HI/LO multiply/divide unit: WIDTH-cycle shift-add / restoring divide plus a sign-fix cycle.
// Divider datapath is built only when ALU_MULDIV_DIV_EN is defined; otherwise DIV/DIVU report op_err.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             op_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_q;
  logic               r_done;
  logic               r_dz;
  logic               r_err;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic               w_is_mul;
  logic               w_div_go;
  logic               w_div_zero;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_fix_mul;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // MULT/DIV are even opcodes: signed variants; magnitudes are taken at latch time
  assign w_signed = ~op[0];
  assign w_a_abs  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_abs  = (w_signed && B[WIDTH-1]) ? -B : B;
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);

  // Upper half accumulates; lower half holds the unconsumed multiplier bits
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
  assign w_fix_mul  = r_neg_q ? -r_acc : r_acc;

`ifdef ALU_MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_r;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_go   = (op[2:1] == 2'b01) && (B != '0);
  assign w_div_zero = (op[2:1] == 2'b01) && (B == '0);
  // Upper half is the partial remainder; quotient bits enter at the LSB
  assign w_dshift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_b};
  assign w_div_next = w_ddiff[WIDTH] ? {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_ddiff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = r_is_div ? w_div_next : w_mul_next;

  always_comb begin
    w_fix_hi = w_fix_mul[2*WIDTH-1:WIDTH];
    w_fix_lo = w_fix_mul[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_is_div <= w_div_go;
      r_neg_r  <= w_signed && A[WIDTH-1];
    end
  end
`else
  assign w_div_go   = 1'b0;
  assign w_div_zero = 1'b0;
  assign w_step     = w_mul_next;
  assign w_fix_hi   = w_fix_mul[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = w_fix_mul[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_err   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul || w_div_go) begin
              r_acc   <= {{WIDTH{1'b0}}, w_a_abs};
              r_b     <= w_b_abs;
              r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= S_RUN;
            end else if (w_div_zero) begin
              r_done <= 1'b1;
              r_dz   <= 1'b1;
            end else if (op == OP_MTHI) begin
              r_hi   <= A;
              r_done <= 1'b1;
            end else if (op == OP_MTLO) begin
              r_lo   <= A;
              r_done <= 1'b1;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_step;
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign op_err   = r_err;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): transaction-level model checked every cycle, plus literal directed cases.
module tb_alu_muldiv;
  localparam int W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_zero, op_err;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .op_err(op_err), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from arithmetic: {hi, lo}
  function automatic logic [63:0] ref_fn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0:    return 64'(sa * sb);
      3'd1:    return {32'b0, a} * {32'b0, b};
      3'd2:    return {32'(sa % sb), 32'(sa / sb)};
      3'd3:    return {a % b, a / b};
      default: return '0;
    endcase
  endfunction

  // Model: an accepted iterative op keeps the unit busy for W+1 cycles, then results land with done
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0, m_err = 1'b0;
  logic [63:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0; m_dz = 1'b0; m_err = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
          end
        end
      end else if (start) begin
        if (op <= 3'd1 || (DIV_EN && op <= 3'd3 && B != 0)) begin
          m_r = ref_fn(op, A, B);
          m_phi = m_r[63:32]; m_plo = m_r[31:0];
          m_left = W + 1;
        end else if (DIV_EN && op <= 3'd3) begin
          m_done = 1'b1; m_dz = 1'b1;
        end else if (op == 3'd4) begin
          m_hi = A; m_done = 1'b1;
        end else if (op == 3'd5) begin
          m_lo = A; m_done = 1'b1;
        end else begin
          m_done = 1'b1; m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("op_err", op_err, m_err);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    bit ok;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) bc++;
      @(posedge clk); #2;
    end
    chk("done_timeout", ok, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  int bc;

  initial begin
    // Model pinned against hand-computed values
    chk("model_mult",  ref_fn(3'd0, 32'hFFFFFFFD, 32'h7), 64'hFFFFFFFF_FFFFFFEB);
    chk("model_multu", ref_fn(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("model_div",   ref_fn(3'd2, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divmn", ref_fn(3'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // Start presented together with reset release is taken on the first edge
    rst_n = 1'b1; start = 1'b1; op = 3'd5; A = 32'h55AA55AA;
    @(posedge clk); #2;
    start = 1'b0;
    chk("first_edge_mtlo", lo, 32'h55AA55AA);
    chk("first_edge_done", done, 1'b1);

    issue(3'd0, 32'hFFFFFFFD, 32'h7);
    wait_done(bc);
    chk("mult_busy_cycles", bc, 33);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #2; start = 1'b1; op = 3'd4; A = 32'hDEADBEEF;
    @(posedge clk); #2; start = 1'b0;
    wait_done(bc);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(3'd4, 32'h12345678, 32'h0);
    chk("mthi_busy", busy, 1'b0);
    issue(3'd3, 32'h00000005, 32'h0);
    chk("divz_busy", busy, 1'b0);
    chk("divz_done", done, 1'b1);
    chk("divz_flag", div_zero, DIV_EN);
    chk("divz_err", op_err, !DIV_EN);
    chk("divz_hi", hi, 32'h12345678);
    chk("divz_lo", lo, 32'h00000001);

    // Flush mid-RUN, then a new MULT on the very next edge
    issue(3'd0, 32'h00001234, 32'h00005678);
    repeat (8) @(posedge clk);
    #2; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_done", done, 1'b0);
    chk("flush_hi", hi, 32'h12345678);
    chk("flush_lo", lo, 32'h00000001);
    start = 1'b1; op = 3'd0; A = 32'h3; B = 32'hFFFFFFFB;
    @(posedge clk); #2;
    start = 1'b0;
    chk("after_flush_busy", busy, 1'b1);
    wait_done(bc);
    chk("after_flush_hi", hi, 32'hFFFFFFFF);
    chk("after_flush_lo", lo, 32'hFFFFFFF1);

    issue(3'd6, 32'hAAAAAAAA, 32'h1);
    chk("rsvd_done", done, 1'b1);
    chk("rsvd_err", op_err, 1'b1);
    chk("rsvd_hi", hi, 32'hFFFFFFFF);
    chk("rsvd_lo", lo, 32'hFFFFFFF1);

`ifdef ALU_MULDIV_DIV_EN
    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    wait_done(bc);
    chk("div_busy_cycles", bc, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(bc);
    chk("divmn_lo", lo, 32'h80000000);
    chk("divmn_hi", hi, 32'h0);
    chk("divmn_flag", div_zero, 1'b0);
`endif

    // Asynchronous reset in the middle of RUN
    issue(3'd1, 32'h0000FFFF, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #2;
      start = (($urandom % 3) == 0);
      op    = 3'($urandom % 8);
      A     = pick();
      B     = (($urandom % 6) == 0) ? 32'h0 : pick();
      flush = busy && (($urandom % 40) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width in bits (legal values 8..64).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port op  input  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 SHALL have port A  input  WIDTH  first operand (dividend, or MTHI/MTLO source).
REQ-007 SHALL have port B  input  WIDTH  second operand (divisor).
REQ-008 SHALL have port flush  input  1  abort the operation in progress.
REQ-009 SHALL have port busy  output  1  high while an iterative operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port div_zero  output  1  valid with done; the divisor was zero.
REQ-012 SHALL have port op_err  output  1  valid with done; the op was reserved or is compiled out.
REQ-013 SHALL have ports hi and lo  output  WIDTH  registered HI/LO results.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> FIX -> IDLE; busy=1 in RUN and FIX only.
REQ-015 SHALL, when start=1 in IDLE with op MULT/MULTU/DIV/DIVU and B!=0 (or any MULT), latch A, B and op and enter RUN at that edge (E0).
REQ-016 SHALL perform exactly one shift-add (MULT) or restoring-subtract (DIV) iteration per cycle in RUN: WIDTH cycles, with a counter going WIDTH-1 down to 0.
REQ-017 SHALL take the absolute values of the operands for signed ops at latch time, and in FIX apply sign correction: product sign = sign(A) xor sign(B); quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-018 SHALL, at the edge leaving FIX (E0+WIDTH+1), write MULT results as {hi,lo} = the 2*WIDTH-bit product, and DIV results as lo = quotient, hi = remainder; done=1 for the following cycle.
REQ-019 SHALL handle signed DIV of the most-negative value by -1 as: lo = most-negative value (wrap), hi = 0, and SHALL NOT raise a flag.
REQ-020 SHALL handle DIV/DIVU with B=0 without entering RUN: hi and lo unchanged; done=1 and div_zero=1 in the next cycle.
REQ-021 SHALL make MTHI/MTLO single-cycle: hi (resp. lo) <= A at the accepting edge; done=1 next cycle; busy stays 0.
REQ-022 SHALL handle reserved ops as: no state change; done=1 and op_err=1 next cycle.
REQ-023 SHALL ignore start while busy=1; no queuing.
REQ-024 SHALL, when flush=1 in RUN or FIX, return to IDLE at that edge, leave hi and lo unchanged, and not pulse done; flush in IDLE has no effect, and flush takes priority over a simultaneous start.
REQ-025 SHALL hold div_zero and op_err at 0 whenever done=0.

Reset
REQ-026 SHALL, with rst_n=0, immediately force state IDLE, busy=0, done=0, div_zero=0, op_err=0, hi=0, lo=0, and counter=0, including in the middle of an operation.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL include the divider datapath (RUN/FIX for DIV/DIVU) when macro ALU_MULDIV_DIV_EN is defined.
REQ-029 SHALL, when ALU_MULDIV_DIV_EN is undefined, omit the divider logic and treat DIV/DIVU exactly like reserved ops (REQ-022), with div_zero always 0; MULT behaviour and latency are identical in both builds.

Verification (WIDTH=32)
REQ-030 SHALL cover: MULT A=FFFFFFFD, B=00000007 -> busy for 33 cycles, then done; hi=FFFFFFFF, lo=FFFFFFEB.
REQ-031 SHALL cover: MULTU A=FFFFFFFF, B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a start issued mid-operation is ignored and the result is unaffected.
REQ-032 SHALL cover: DIV A=FFFFFFF9 (-7), B=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
REQ-033 SHALL cover: after MTHI A=12345678, DIVU B=0 -> done and div_zero the next cycle; hi=12345678 unchanged; busy never 1.
REQ-034 SHALL cover: MULT started, flush at cycle 10 -> no done, hi/lo unchanged; new MULT accepted the next cycle; rst_n low mid-RUN -> hi=lo=0 and busy=0 immediately.
REQ-035 SHALL cover: op=110, and DIVU in a build without ALU_MULDIV_DIV_EN -> done=1 and op_err=1 the next cycle; hi/lo unchanged.
